// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEASURE,
      ST_LOCKED
   } state_t;

   localparam int DEF_DIV_RATIO  = 4;
   localparam int DEF_TOL        = 0;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int ERR_CNT_W      = 8;

endpackage

// File: rtl/clk_div_monitor_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector producing a one-cycle pulse.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a locally divided clock in source-clock cycles,
// tracks lock against the expected ratio and counts period errors.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int DIV_RATIO   = DEF_DIV_RATIO,
   parameter int TOL         = DEF_TOL,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 div_clk_i,
   input  logic                 err_clr_i,
   output logic [CNT_WIDTH-1:0] period_o,
   output logic                 period_valid_o,
   output logic                 locked_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int LIMIT  = DIV_RATIO + TOL + 1;
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   function automatic logic is_good(input logic [CNT_WIDTH-1:0] p);
      int d;
      d = int'(p) - DIV_RATIO;
      if (d < 0) d = -d;
      return (d <= TOL);
   endfunction

   logic                 w_rise;
   state_t               r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [GOOD_W-1:0]    r_good, w_good_nxt, w_good_inc;
   logic                 w_locked_nxt;
   logic                 w_upd;
   logic                 w_err;
   logic [CNT_WIDTH-1:0] r_period;
   logic                 r_pvalid;
   logic                 r_locked;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk  (clk_i),
      .i_rst_n(rst_n),
      .i_d    (div_clk_i),
      .o_rise (w_rise)
   );

   assign w_good_inc = r_good + GOOD_W'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = w_rise ? CNT_WIDTH'(1) : sat_inc(r_cnt);
      w_good_nxt   = r_good;
      w_locked_nxt = r_locked;
      w_upd        = 1'b0;
      w_err        = 1'b0;
      if (!en_i) begin
         // Disable wins over everything and silently drops any partial period.
         w_state_nxt  = ST_IDLE;
         w_cnt_nxt    = '0;
         w_good_nxt   = '0;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt  = ST_ARM;
               w_cnt_nxt    = '0;
               w_good_nxt   = '0;
               w_locked_nxt = 1'b0;
            end
            ST_ARM: begin
               w_good_nxt   = '0;
               w_locked_nxt = 1'b0;
               if (w_rise) w_state_nxt = ST_MEASURE;
               else        w_cnt_nxt   = '0;
            end
            ST_MEASURE, ST_LOCKED: begin
               if (w_rise) begin
                  w_upd = 1'b1;
                  if (is_good(r_cnt)) begin
                     if (r_state == ST_MEASURE) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == GOOD_W'(LOCK_COUNT)) begin
                           w_state_nxt  = ST_LOCKED;
                           w_locked_nxt = 1'b1;
                        end
                     end
                  end else begin
                     w_err        = 1'b1;
                     w_good_nxt   = '0;
                     w_locked_nxt = 1'b0;
                     w_state_nxt  = ST_MEASURE;
                  end
               end else if (r_cnt >= CNT_WIDTH'(LIMIT)) begin
                  // A rise landing exactly on the limit is a measured period, not a timeout.
                  w_err        = 1'b1;
                  w_good_nxt   = '0;
                  w_locked_nxt = 1'b0;
                  w_state_nxt  = ST_ARM;
                  w_cnt_nxt    = '0;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_good    <= '0;
         r_period  <= '0;
         r_pvalid  <= 1'b0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_good   <= w_good_nxt;
         r_pvalid <= w_upd;
         r_locked <= w_locked_nxt;
         r_err    <= w_err;
         if (w_upd) r_period <= r_cnt;
         // Clear has priority so an error in the clearing cycle is not counted.
         if (err_clr_i)                      r_err_cnt <= '0;
         else if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign period_o       = r_period;
   assign period_valid_o = r_pvalid;
   assign locked_o       = r_locked;
   assign err_o          = r_err;
   assign err_cnt_o      = r_err_cnt;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a TOL=0 and a TOL=1 instance share stimulus.
module tb_clk_div_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       div_clk;
   logic       err_clr;

   logic [7:0] d0_period, d1_period;
   logic       d0_pv, d1_pv, d0_lk, d1_lk, d0_err, d1_err;
   logic [7:0] d0_ecnt, d1_ecnt;

   typedef struct {
      int period;
      int locked;
   } exp_t;

   exp_t exp_q[$];
   int   seq_p[$];
   int   seq_l[$];
   int   errors = 0;
   int   checks = 0;
   int   err_seen0 = 0;
   int   err_seen1 = 0;
   bit   mon_sel = 1'b0;

   always #5 clk = ~clk;

   clk_div_monitor #(
      .DIV_RATIO(4), .TOL(0), .LOCK_COUNT(4), .SYNC_STAGES(2), .CNT_WIDTH(8)
   ) u_dut0 (
      .clk_i(clk), .rst_n(rst_n), .en_i(en), .div_clk_i(div_clk), .err_clr_i(err_clr),
      .period_o(d0_period), .period_valid_o(d0_pv), .locked_o(d0_lk),
      .err_o(d0_err), .err_cnt_o(d0_ecnt)
   );

   clk_div_monitor #(
      .DIV_RATIO(4), .TOL(1), .LOCK_COUNT(4), .SYNC_STAGES(2), .CNT_WIDTH(8)
   ) u_dut1 (
      .clk_i(clk), .rst_n(rst_n), .en_i(en), .div_clk_i(div_clk), .err_clr_i(err_clr),
      .period_o(d1_period), .period_valid_o(d1_pv), .locked_o(d1_lk),
      .err_o(d1_err), .err_cnt_o(d1_ecnt)
   );

   // One clock step; outputs are sampled and scored on the falling edge.
   task automatic tick();
      exp_t       e;
      logic       pv, lk;
      logic [7:0] per;
      @(negedge clk);
      if (d0_err) err_seen0++;
      if (d1_err) err_seen1++;
      pv  = mon_sel ? d1_pv : d0_pv;
      lk  = mon_sel ? d1_lk : d0_lk;
      per = mon_sel ? d1_period : d0_period;
      if (pv) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: period_valid_o=1 period_o=%0d, required no pulse", per);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (per !== 8'(e.period)) begin
               errors++;
               $display("FAIL period: period_o=%0d required %0d", per, e.period);
            end
            checks++;
            if (lk !== (e.locked != 0)) begin
               errors++;
               $display("FAIL locked_at_valid: locked_o=%0d required %0d", lk, e.locked);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int p);
      div_clk = 1'b1;
      repeat ((p + 1) / 2) tick();
      div_clk = 1'b0;
      repeat (p - (p + 1) / 2) tick();
   endtask

   // Each rise after the first closes the previous period, so its expectation is pushed first.
   task automatic run_seq();
      for (int i = 0; i < seq_p.size(); i++) begin
         if (i > 0) exp_q.push_back('{seq_p[i-1], seq_l[i-1]});
         drive_period(seq_p[i]);
      end
   endtask

   task automatic start_mon();
      en = 1'b0;
      repeat (2) tick();
      en = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; div_clk = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (d0_period !== 8'd0) begin errors++; $display("FAIL rst_period: %0d required 0", d0_period); end
      checks++; if (d0_pv !== 1'b0)     begin errors++; $display("FAIL rst_pvalid: %0d required 0", d0_pv); end
      checks++; if (d0_lk !== 1'b0)     begin errors++; $display("FAIL rst_locked: %0d required 0", d0_lk); end
      checks++; if (d0_err !== 1'b0)    begin errors++; $display("FAIL rst_err: %0d required 0", d0_err); end
      checks++; if (d0_ecnt !== 8'd0)   begin errors++; $display("FAIL rst_errcnt: %0d required 0", d0_ecnt); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ideal();
      int e0;
      mon_sel = 1'b0;
      start_mon();
      e0 = err_seen0;
      seq_p = '{4, 4, 4, 4, 4, 4};
      seq_l = '{0, 0, 0, 1, 1};
      run_seq();
      repeat (2) tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ideal_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      checks++; if (d0_lk !== 1'b1) begin errors++; $display("FAIL ideal_locked: %0d required 1", d0_lk); end
      checks++; if (err_seen0 - e0 != 0) begin errors++; $display("FAIL ideal_err_pulses: %0d required 0", err_seen0 - e0); end
      checks++; if (d0_ecnt !== 8'd0) begin errors++; $display("FAIL ideal_errcnt: %0d required 0", d0_ecnt); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_tolerance();
      int e1;
      mon_sel = 1'b1;
      start_mon();
      e1 = err_seen1;
      seq_p = '{4, 5, 4, 5, 4, 6, 5, 4, 5, 4, 4};
      seq_l = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
      run_seq();
      repeat (2) tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tol_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      checks++; if (d1_lk !== 1'b1) begin errors++; $display("FAIL tol_relock: %0d required 1", d1_lk); end
      checks++; if (err_seen1 - e1 != 1) begin errors++; $display("FAIL tol_err_pulses: %0d required 1", err_seen1 - e1); end
      checks++; if (d1_ecnt !== 8'd1) begin errors++; $display("FAIL tol_errcnt: %0d required 1", d1_ecnt); end
      en = 1'b0;
      tick();
      mon_sel = 1'b0;
   endtask

   task automatic test_timeout();
      int e0;
      mon_sel = 1'b0;
      start_mon();
      seq_p = '{4, 4, 4, 4, 4};
      seq_l = '{0, 0, 0, 1};
      run_seq();
      checks++; if (d0_lk !== 1'b1) begin errors++; $display("FAIL to_prelock: %0d required 1", d0_lk); end
      e0 = err_seen0;
      repeat (6) tick();
      checks++; if (err_seen0 - e0 != 1) begin errors++; $display("FAIL to_err_pulses: %0d required 1", err_seen0 - e0); end
      checks++; if (d0_lk !== 1'b0) begin errors++; $display("FAIL to_locked: %0d required 0", d0_lk); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      seq_p = '{4, 4};
      seq_l = '{0};
      run_seq();
      repeat (2) tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_rearm_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      mon_sel = 1'b0;
      start_mon();
      seq_p = '{4, 4, 4, 4, 4};
      seq_l = '{0, 0, 0, 1};
      run_seq();
      checks++; if (d0_lk !== 1'b1) begin errors++; $display("FAIL rm_prelock: %0d required 1", d0_lk); end
      rst_n = 1'b0;
      #2;
      checks++; if (d0_lk !== 1'b0)     begin errors++; $display("FAIL rm_locked: %0d required 0", d0_lk); end
      checks++; if (d0_period !== 8'd0) begin errors++; $display("FAIL rm_period: %0d required 0", d0_period); end
      checks++; if (d0_ecnt !== 8'd0)   begin errors++; $display("FAIL rm_errcnt: %0d required 0", d0_ecnt); end
      checks++; if (d0_pv !== 1'b0 || d0_err !== 1'b0) begin errors++; $display("FAIL rm_pulses: pv=%0d err=%0d required 0", d0_pv, d0_err); end
      #1;
      rst_n = 1'b1;
      tick();
      seq_p = '{4, 4, 4, 4, 4};
      seq_l = '{0, 0, 0, 1};
      run_seq();
      repeat (2) tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      checks++; if (d0_lk !== 1'b1) begin errors++; $display("FAIL rm_relock: %0d required 1", d0_lk); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_err_clr();
      int e0;
      mon_sel = 1'b0;
      start_mon();
      e0 = err_seen0;
      seq_p = '{3, 3, 3, 3};
      seq_l = '{0, 0, 0};
      run_seq();
      checks++; if (d0_ecnt !== 8'd3) begin errors++; $display("FAIL clr_pre_errcnt: %0d required 3", d0_ecnt); end
      err_clr = 1'b1;
      exp_q.push_back('{3, 0});
      drive_period(3);
      err_clr = 1'b0;
      repeat (2) tick();
      checks++; if (d0_ecnt !== 8'd0) begin errors++; $display("FAIL clr_errcnt: %0d required 0", d0_ecnt); end
      checks++; if (err_seen0 - e0 != 4) begin errors++; $display("FAIL clr_err_pulses: %0d required 4", err_seen0 - e0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clr_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_err_saturate();
      mon_sel = 1'b0;
      start_mon();
      seq_p.delete();
      seq_l.delete();
      for (int i = 0; i < 301; i++) seq_p.push_back(3);
      for (int i = 0; i < 300; i++) seq_l.push_back(0);
      run_seq();
      repeat (2) tick();
      checks++; if (d0_ecnt !== 8'd255) begin errors++; $display("FAIL sat_errcnt: %0d required 255", d0_ecnt); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_en_drop();
      int e0;
      mon_sel = 1'b0;
      start_mon();
      seq_p = '{4, 4, 4, 4, 4};
      seq_l = '{0, 0, 0, 1};
      run_seq();
      checks++; if (d0_lk !== 1'b1) begin errors++; $display("FAIL en_prelock: %0d required 1", d0_lk); end
      e0 = err_seen0;
      en = 1'b0;
      tick();
      checks++; if (d0_lk !== 1'b0) begin errors++; $display("FAIL en_locked: %0d required 0", d0_lk); end
      repeat (8) tick();
      checks++; if (err_seen0 - e0 != 0) begin errors++; $display("FAIL en_err_pulses: %0d required 0", err_seen0 - e0); end
      checks++; if (d0_ecnt !== 8'd255) begin errors++; $display("FAIL en_errcnt_kept: %0d required 255", d0_ecnt); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL en_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      en = 1'b1;
      repeat (2) tick();
      seq_p = '{4, 4};
      seq_l = '{0};
      run_seq();
      repeat (2) tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL en_rearm_drain: %0d pending required 0", exp_q.size()); exp_q.delete(); end
      en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_tolerance();
      test_timeout();
      test_reset_mid();
      test_err_clr();
      test_err_saturate();
      test_en_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
